itr_ctrl: RTL and testbench



---
 rtl/itr_ctrl.sv | 154 +++++++++++++++
 tb/tb_itr_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itr_ctrl.sv
// itr_ctrl: interrupt controller in front of the processor itr input.
// Latches rising edges of NSRC request lines as pending, masks them, picks the
// lowest enabled index, pulses itr for one cycle and holds the source in
// service until firmware acknowledges it or the service timer expires.
module itr_ctrl #(
  parameter int NSRC   = 4,
  parameter int NUBITS = 16,
  parameter int NBIOIN = 2,
  parameter int NBIOOU = 2,
  parameter int A_MSK  = 0,
  parameter int A_ACK  = 1,
  parameter int A_OVC  = 2,
  parameter int A_VEC  = 0,
  parameter int A_PND  = 1,
  parameter int TMOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src,
  input  logic [NUBITS-1:0] io_out,
  input  logic [NBIOOU-1:0] addr_out,
  input  logic              out_en,
  input  logic [NBIOIN-1:0] addr_in,
  input  logic              req_in,
  output logic [NUBITS-1:0] rd_data,
  output logic              rd_hit,
  output logic              itr
);

  localparam int VW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int TW = $clog2(TMOUT + 1);

  typedef enum logic [1:0] {IDLE, FIRE, SERV} state_t;

  state_t              state_q;
  logic [NSRC-1:0]     src_q, pnd_q, pnd_d, msk_q, ovr_q, ovr_d;
  logic [NSRC-1:0]     edg, act, vec_oh, ack_m, tmo_m, ovc_m;
  logic [VW-1:0]       vec_q, sel;
  logic [TW-1:0]       tcnt_q;
  logic                itr_q, rd_hit_q, rd_hit_d;
  logic [NUBITS-1:0]   rd_data_q, rd_data_d, vec_word;
  logic [2*NSRC+NUBITS-1:0] pnd_word;
  logic                wr_msk, wr_ack, wr_ovc, ack, tmo;
  logic                unused_io;

  // Upper data bits are not used by any register of this block.
  assign unused_io = ^io_out[NUBITS-1:NSRC];

  assign wr_msk = out_en && (addr_out == NBIOOU'(A_MSK));
  assign wr_ack = out_en && (addr_out == NBIOOU'(A_ACK));
  assign wr_ovc = out_en && (addr_out == NBIOOU'(A_OVC));

  // Ack only means something while a source is in service.
  assign ack = wr_ack && (state_q == SERV);
  assign tmo = (state_q == SERV) && !wr_ack && (tcnt_q == TW'(TMOUT - 1));

  assign edg    = src & ~src_q;
  assign act    = pnd_q & msk_q;
  assign vec_oh = NSRC'(1) << vec_q;
  assign ack_m  = {NSRC{ack}} & vec_oh;
  assign tmo_m  = {NSRC{tmo}} & vec_oh;
  assign ovc_m  = {NSRC{wr_ovc}} & io_out[NSRC-1:0];

  // Pending/overrun next state: new edges beat ack clears and overrun clears;
  // an edge coinciding with the ack of its own source is not an overrun.
  always_comb begin
    pnd_d = (pnd_q & ~ack_m) | edg;
    ovr_d = (ovr_q & ~ovc_m) | (edg & pnd_q & ~ack_m) | tmo_m;
  end

  // Lowest-index enabled pending source.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (act[i]) sel = VW'(i);
  end

  // Read mux for the two status words.
  always_comb begin
    vec_word             = '0;
    vec_word[NUBITS-1]   = (state_q != IDLE);
    vec_word[VW-1:0]     = vec_q;
    pnd_word             = {{NUBITS{1'b0}}, ovr_q, pnd_q};
    rd_hit_d             = 1'b0;
    rd_data_d            = rd_data_q;
    if (req_in && (addr_in == NBIOIN'(A_VEC))) begin
      rd_hit_d  = 1'b1;
      rd_data_d = vec_word;
    end else if (req_in && (addr_in == NBIOIN'(A_PND))) begin
      rd_hit_d  = 1'b1;
      rd_data_d = pnd_word[NUBITS-1:0];
    end
  end

  // Source history; also tracked during reset so a line high at release is no edge.
  always_ff @(posedge clk) src_q <= src;

  // Pending, overrun and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pnd_q <= '0;
      ovr_q <= '0;
      msk_q <= '0;
    end else begin
      pnd_q <= pnd_d;
      ovr_q <= ovr_d;
      if (wr_msk) msk_q <= io_out[NSRC-1:0];
    end
  end

  // Service FSM with registered itr pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      tcnt_q  <= '0;
      itr_q   <= 1'b0;
    end else begin
      itr_q <= 1'b0;
      case (state_q)
        IDLE: if (|act) begin
          vec_q   <= sel;
          state_q <= FIRE;
        end
        FIRE: begin
          itr_q   <= 1'b1;
          tcnt_q  <= '0;
          state_q <= SERV;
        end
        SERV: begin
          if (ack || tmo) state_q <= IDLE;
          else            tcnt_q  <= tcnt_q + TW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered read port; data holds on misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_hit_q  <= rd_hit_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign itr     = itr_q;
  assign rd_hit  = rd_hit_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Bench for itr_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the controller.
module tb_itr_ctrl;
  localparam int TMOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src = '0;
  logic [15:0] io_out = '0;
  logic [1:0]  addr_out = '0, addr_in = '0;
  logic        out_en = 1'b0, req_in = 1'b0;
  wire  [15:0] rd_data;
  wire         rd_hit, itr;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  itr_ctrl #(.TMOUT(TMOUT)) dut (
    .clk(clk), .rst(rst), .src(src), .io_out(io_out), .addr_out(addr_out),
    .out_en(out_en), .addr_in(addr_in), .req_in(req_in),
    .rd_data(rd_data), .rd_hit(rd_hit), .itr(itr)
  );

  // Behavioural model: phase 0 idle, 1 about to fire, 2 in service.
  bit [3:0]  m_srcq, m_pnd, m_msk, m_ovr;
  int        m_phase, m_vec, m_t;
  bit        m_itr, m_rdhit;
  bit [15:0] m_rd;

  function automatic void model_step();
    bit [3:0] np, no, act;
    bit       ackw, ack, tmo, found;
    int       nphase, nvec, nt;
    if (rst) begin
      m_srcq = src; m_pnd = 0; m_msk = 0; m_ovr = 0;
      m_phase = 0; m_vec = 0; m_t = 0; m_itr = 0; m_rdhit = 0; m_rd = 0;
      return;
    end
    ackw = out_en && addr_out == 2'd1;
    ack  = ackw && m_phase == 2;
    tmo  = m_phase == 2 && !ackw && m_t == TMOUT - 1;
    if (req_in && addr_in == 2'd0) begin
      m_rdhit = 1; m_rd = (m_phase != 0 ? 16'h8000 : 16'h0) | 16'(m_vec);
    end else if (req_in && addr_in == 2'd1) begin
      m_rdhit = 1; m_rd = {8'h00, m_ovr, m_pnd};
    end else m_rdhit = 0;
    for (int i = 0; i < 4; i++) begin
      bit e, mine;
      e = src[i] && !m_srcq[i];
      mine = (i == m_vec);
      np[i] = e ? 1'b1 : (ack && mine) ? 1'b0 : m_pnd[i];
      if ((e && m_pnd[i] && !(ack && mine)) || (tmo && mine)) no[i] = 1;
      else if (out_en && addr_out == 2'd2 && io_out[i]) no[i] = 0;
      else no[i] = m_ovr[i];
    end
    nphase = m_phase; nvec = m_vec; nt = m_t; m_itr = 0;
    act = m_pnd & m_msk;
    case (m_phase)
      0: if (act != 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) if (act[i] && !found) begin nvec = i; found = 1; end
        nphase = 1;
      end
      1: begin m_itr = 1; nt = 0; nphase = 2; end
      default: if (ack || tmo) nphase = 0; else nt = m_t + 1;
    endcase
    if (out_en && addr_out == 2'd0) m_msk = io_out[3:0];
    m_pnd = np; m_ovr = no; m_phase = nphase; m_vec = nvec; m_t = nt; m_srcq = src;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    out_en = 1; addr_out = a; io_out = d;
    tick();
    out_en = 0; io_out = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    req_in = 1; addr_in = a;
    tick();
    req_in = 0;
  endtask

  task automatic wait_itr(output bit ok);
    int n = 0;
    while (itr !== 1'b1 && n < 30) begin tick(); n++; end
    ok = (itr === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1; src = 0;
    tick(); tick();
    checks++;
    if (itr !== 1'b0 || rd_hit !== 1'b0 || rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: itr=%b rd_hit=%b rd_data=%h required 0/0/0000", itr, rd_hit, rd_data);
    end
    rst = 0;
    rd(2'd1);
    checks++;
    if (rd_hit !== 1'b1 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL reset_pnd: rd_hit=%b rd_data=%h required 1/0000", rd_hit, rd_data);
    end
    rd(2'd3);
    checks++;
    if (rd_hit !== 1'b0 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL miss_addr: rd_hit=%b rd_data=%h required 0/0000 (held)", rd_hit, rd_data);
    end
  endtask

  task automatic test_basic();
    logic [3:0] seen;
    wr(2'd0, 16'h000F);
    repeat (3) tick();
    src = 4'b0100; tick(); seen[0] = itr;
    src = 0;       tick(); seen[1] = itr;
    tick(); seen[2] = itr;
    tick(); seen[3] = itr;
    checks++;
    if (seen !== 4'b0100) begin
      errors++; $display("FAIL itr_latency: itr after ticks 1..4 = %b required 0100", seen);
    end
    rd(2'd0);
    checks++;
    if (rd_hit !== 1'b1 || rd_data !== 16'h8002) begin
      errors++; $display("FAIL vec_busy: rd_hit=%b rd_data=%h required 1/8002", rd_hit, rd_data);
    end
    wr(2'd1, 16'hFFFF);
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++; $display("FAIL pnd_after_ack: rd_data=%h required 0000", rd_data);
    end
    rd(2'd0);
    checks++;
    if (rd_data !== 16'h0002) begin
      errors++; $display("FAIL vec_idle: rd_data=%h required 0002", rd_data);
    end
  endtask

  task automatic test_priority();
    bit ok; int ack_c, c2;
    src = 4'b1010; tick(); src = 0;
    wait_itr(ok);
    rd(2'd0);
    checks++;
    if (!ok || rd_data !== 16'h8001) begin
      errors++; $display("FAIL prio_first: itr_seen=%0d rd_data=%h required 1/8001", ok, rd_data);
    end
    wr(2'd1, 16'h0); ack_c = cyc;
    wait_itr(ok); c2 = cyc;
    checks++;
    if (!ok || c2 - ack_c != 2) begin
      errors++; $display("FAIL prio_gap: itr_seen=%0d cycles ack->itr=%0d required 2", ok, c2 - ack_c);
    end
    rd(2'd0);
    checks++;
    if (rd_data !== 16'h8003) begin
      errors++; $display("FAIL prio_second: rd_data=%h required 8003", rd_data);
    end
    wr(2'd1, 16'h0);
  endtask

  task automatic test_mask();
    bit ok, any;
    wr(2'd0, 16'h0001);
    src = 4'b0100; tick(); src = 0;
    any = 0;
    repeat (6) begin tick(); any |= itr; end
    checks++;
    if (any !== 1'b0) begin
      errors++; $display("FAIL masked_itr: itr seen=%b required 0", any);
    end
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0004) begin
      errors++; $display("FAIL masked_pnd: rd_data=%h required 0004", rd_data);
    end
    wr(2'd0, 16'h0004);
    wait_itr(ok);
    rd(2'd0);
    checks++;
    if (!ok || rd_data !== 16'h8002) begin
      errors++; $display("FAIL unmask_fire: itr_seen=%0d rd_data=%h required 1/8002", ok, rd_data);
    end
    wr(2'd1, 16'h0);
    wr(2'd0, 16'h000F);
  endtask

  task automatic test_overrun();
    bit ok;
    src = 4'b0001; tick();
    wait_itr(ok);
    src = 0; tick();
    src = 4'b0001; tick();
    rd(2'd1);
    checks++;
    if (!ok || rd_data !== 16'h0011) begin
      errors++; $display("FAIL ovr_set: itr_seen=%0d rd_data=%h required 1/0011", ok, rd_data);
    end
    wr(2'd2, 16'h0001);
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0001) begin
      errors++; $display("FAIL ovr_clear: rd_data=%h required 0001", rd_data);
    end
    wr(2'd1, 16'h0);
    src = 0; tick();
  endtask

  task automatic test_timeout();
    bit ok; int c1, c2;
    src = 4'b0010; tick(); src = 0;
    wait_itr(ok); c1 = cyc;
    tick();
    wait_itr(ok); c2 = cyc;
    checks++;
    if (!ok || c2 - c1 != TMOUT + 2) begin
      errors++; $display("FAIL tmo_refire: itr_seen=%0d itr spacing=%0d required %0d", ok, c2 - c1, TMOUT + 2);
    end
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0022) begin
      errors++; $display("FAIL tmo_ovr: rd_data=%h required 0022", rd_data);
    end
    wr(2'd1, 16'h0);
    wr(2'd2, 16'h0002);
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++; $display("FAIL tmo_cleanup: rd_data=%h required 0000", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, any;
    src = 4'b0001; tick();
    wait_itr(ok);
    tick();
    rst = 1; tick(); rst = 0;
    checks++;
    if (!ok || itr !== 1'b0) begin
      errors++; $display("FAIL rst_mid_itr: itr_seen=%0d itr=%b required 1/0", ok, itr);
    end
    rd(2'd1);
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_pnd: rd_data=%h required 0000", rd_data);
    end
    wr(2'd0, 16'h000F);
    any = 0;
    repeat (15) begin tick(); any |= itr; end
    rd(2'd0);
    checks++;
    if (any !== 1'b0 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL rst_no_spurious: itr seen=%b vec=%h required 0/0000", any, rd_data);
    end
    src = 0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) src[i] = ~src[i];
      out_en   = ($urandom_range(3) == 0);
      addr_out = 2'($urandom_range(3));
      io_out   = 16'($urandom);
      req_in   = $urandom_range(1) == 1;
      addr_in  = 2'($urandom_range(3));
      tick();
      checks++;
      if (itr !== m_itr || rd_hit !== m_rdhit || (m_rdhit && rd_data !== m_rd)) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand_cycle %0d: itr=%b rd_hit=%b rd_data=%h required %b/%b/%h",
                   n, itr, rd_hit, rd_data, m_itr, m_rdhit, m_rd);
      end
    end
    out_en = 0; req_in = 0; src = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
